adc_event_irq_ctrl: RTL and testbench

Consumes the per-channel level-type event lines produced by the ADC threshold event controller (data_event_intr) and turns them into a serialized, acknowledged interrupt stream toward the host/CPU side. Each channel is rising-edge detected and latched into a sticky pending bit. A fixed-priority arbiter presents one channel ID at a time over a valid/ack handshake. A holdoff timer runs after each ack, and per-channel saturating occurrence counters and overflow flags are provided for diagnostics. The block sits directly downstream of the event controller in the adc_wclk domain.

---
 rtl/adc_event_irq_ctrl.sv | 127 ++++++++++++
 tb/tb_adc_event_irq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_event_irq_ctrl.sv
// Serialises per-channel ADC threshold events into one acknowledged interrupt stream.
// Rising edges latch sticky pending bits. A fixed-priority arbiter picks the lowest index.
module adc_event_irq_ctrl #(
    parameter int unsigned NUM_CH  = 10,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned HOLDOFF = 4
) (
    input  logic              adc_wclk,
    input  logic              adc_wclk_rst,
    input  logic [NUM_CH-1:0] data_event_intr,
    input  logic [NUM_CH-1:0] evt_en,
    input  logic              irq_ack,
    input  logic              cnt_clr,
    input  logic [ID_W-1:0]   cnt_sel,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    output logic [NUM_CH-1:0] pend_status,
    output logic [NUM_CH-1:0] ovf_status,
    output logic [CNT_W-1:0]  cnt_val
);

    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_CH-1:0]   prev_q, pend_q, pend_d, ovf_q, ovf_d;
    logic [NUM_CH-1:0]   rise, set_evt, ack_clr;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_val_q, cnt_val_d;
    logic [ID_W-1:0]     first_id;
    logic                ack_fire;

    always_comb begin
        rise     = data_event_intr & ~prev_q;
        set_evt  = rise & evt_en;
        ack_fire = (state_q == StReq) && irq_ack;
        ack_clr  = ack_fire ? (NUM_CH'(1) << id_q) : '0;
        // A new edge on the channel being acked keeps it pending.
        pend_d   = (pend_q & ~ack_clr) | set_evt;
        ovf_d    = cnt_clr ? '0 : (ovf_q | (set_evt & pend_q));
    end

    always_comb begin
        first_id = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (pend_q[i]) first_id = ID_W'(i);
        end
    end

    always_comb begin
        cnt_val_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cnt_sel == ID_W'(i)) cnt_val_d = cnt_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    id_d    = first_id;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (irq_ack) begin
                    if (HOLDOFF > 0) begin
                        state_d = StHold;
                        hold_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (hold_q == HOLD_LAST) state_d = StIdle;
                else                     hold_d  = hold_q + HOLD_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge adc_wclk) begin
        if (adc_wclk_rst) begin
            state_q   <= StIdle;
            id_q      <= '0;
            hold_q    <= '0;
            prev_q    <= '1;
            pend_q    <= '0;
            ovf_q     <= '0;
            cnt_val_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            hold_q    <= hold_d;
            prev_q    <= data_event_intr;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            cnt_val_q <= cnt_val_d;
        end
    end

    always_ff @(posedge adc_wclk) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (adc_wclk_rst || cnt_clr) begin
                cnt_q[i] <= '0;
            end else if (set_evt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign irq_valid   = (state_q == StReq);
    assign irq_id      = id_q;
    assign pend_status = pend_q;
    assign ovf_status  = ovf_q;
    assign cnt_val     = cnt_val_q;

endmodule

// File: tb/tb_adc_event_irq_ctrl.sv
// Directed bench for adc_event_irq_ctrl. Expected irq_id values are queued when events are
// raised and are popped as the arbiter presents requests.
module tb_adc_event_irq_ctrl;

    localparam int unsigned NUM_CH = 10;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned CNT_W  = 8;

    logic              adc_wclk = 1'b0;
    logic              adc_wclk_rst;
    logic [NUM_CH-1:0] data_event_intr;
    logic [NUM_CH-1:0] evt_en;
    logic              irq_ack;
    logic              cnt_clr;
    logic [ID_W-1:0]   cnt_sel;
    logic              irq_valid;
    logic [ID_W-1:0]   irq_id;
    logic [NUM_CH-1:0] pend_status;
    logic [NUM_CH-1:0] ovf_status;
    logic [CNT_W-1:0]  cnt_val;

    int tests  = 0;
    int failed = 0;
    int exp_q[$];
    int gap;

    adc_event_irq_ctrl #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W),
        .CNT_W  (CNT_W),
        .HOLDOFF(4)
    ) dut (
        .adc_wclk       (adc_wclk),
        .adc_wclk_rst   (adc_wclk_rst),
        .data_event_intr(data_event_intr),
        .evt_en         (evt_en),
        .irq_ack        (irq_ack),
        .cnt_clr        (cnt_clr),
        .cnt_sel        (cnt_sel),
        .irq_valid      (irq_valid),
        .irq_id         (irq_id),
        .pend_status    (pend_status),
        .ovf_status     (ovf_status),
        .cnt_val        (cnt_val)
    );

    always #5 adc_wclk = ~adc_wclk;

    task automatic tick();
        @(posedge adc_wclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a request, checks it against the scoreboard, optionally acks it.
    task automatic serve(input string tag, input bit do_ack, output int waited);
        int exp_id;
        waited = 0;
        while (!irq_valid && waited < 40) begin
            waited++;
            tick();
        end
        check({tag, "_valid"}, 32'(irq_valid), 32'd1);
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_id"}, 32'(irq_id), 32'(exp_id));
        if (do_ack) begin
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
        end
    endtask

    initial begin
        adc_wclk_rst    = 1'b1;
        data_event_intr = 10'h3FF;
        evt_en          = 10'h3FF;
        irq_ack         = 1'b0;
        cnt_clr         = 1'b0;
        cnt_sel         = '0;
        idle(3);
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pend", 32'(pend_status), 32'd0);
        check("rst_ovf", 32'(ovf_status), 32'd0);
        check("rst_cnt_val", 32'(cnt_val), 32'd0);

        // Lines already high at reset release must not raise events.
        adc_wclk_rst = 1'b0;
        idle(3);
        check("high_at_rel_pend", 32'(pend_status), 32'd0);
        check("high_at_rel_valid", 32'(irq_valid), 32'd0);
        data_event_intr = '0;
        idle(2);

        // ch3: pend after first edge, irq_valid after second.
        data_event_intr = 10'h008;
        exp_q.push_back(3);
        tick();
        data_event_intr = '0;
        check("lat1_pend", 32'(pend_status), 32'h008);
        check("lat1_valid", 32'(irq_valid), 32'd0);
        tick();
        check("lat2_valid", 32'(irq_valid), 32'd1);
        serve("ch3", 1'b1, gap);
        check("ch3_ack_pend", 32'(pend_status), 32'd0);
        check("ch3_ack_valid", 32'(irq_valid), 32'd0);
        idle(6);

        // ch7 and ch2 together: lowest index first, then a 5-cycle gap.
        data_event_intr = 10'h084;
        exp_q.push_back(2);
        exp_q.push_back(7);
        tick();
        data_event_intr = '0;
        serve("ch2", 1'b1, gap);
        serve("ch7", 1'b1, gap);
        check("holdoff_gap", 32'(gap), 32'd5);
        check("ch7_ack_pend", 32'(pend_status), 32'd0);
        idle(6);

        // ch1 arriving during ch5 request does not preempt it.
        data_event_intr = 10'h020;
        exp_q.push_back(5);
        tick();
        data_event_intr = '0;
        tick();
        data_event_intr = 10'h002;
        exp_q.push_back(1);
        tick();
        data_event_intr = '0;
        tick();
        check("hold_id_stable", 32'(irq_id), 32'd5);
        check("hold_pend", 32'(pend_status), 32'h022);
        serve("ch5", 1'b1, gap);
        serve("ch1", 1'b1, gap);
        check("ch1_gap", 32'(gap), 32'd5);
        idle(6);

        // ch4 pulsed three times before ack: overflow and count of 3.
        exp_q.push_back(4);
        for (int i = 0; i < 3; i++) begin
            data_event_intr = 10'h010;
            tick();
            data_event_intr = '0;
            tick();
        end
        check("ch4_ovf", 32'(ovf_status), 32'h010);
        cnt_sel = 4'd4;
        tick();
        check("ch4_cnt", 32'(cnt_val), 32'd3);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_ovf", 32'(ovf_status), 32'd0);
        check("clr_pend_kept", 32'(pend_status), 32'h010);
        tick();
        check("clr_cnt", 32'(cnt_val), 32'd0);
        serve("ch4", 1'b1, gap);
        idle(6);

        // ch6 disabled: no pend, no count.
        evt_en = 10'h3BF;
        data_event_intr = 10'h040;
        tick();
        data_event_intr = '0;
        idle(2);
        check("dis_pend", 32'(pend_status), 32'd0);
        check("dis_valid", 32'(irq_valid), 32'd0);
        cnt_sel = 4'd6;
        tick();
        check("dis_cnt", 32'(cnt_val), 32'd0);
        evt_en = 10'h3FF;

        // ch6 rising on the ack cycle: set wins, overflow flagged, re-requested.
        data_event_intr = 10'h040;
        exp_q.push_back(6);
        tick();
        data_event_intr = '0;
        serve("ch6", 1'b0, gap);
        irq_ack = 1'b1;
        data_event_intr = 10'h040;
        exp_q.push_back(6);
        tick();
        irq_ack = 1'b0;
        data_event_intr = '0;
        check("ack_rise_pend", 32'(pend_status), 32'h040);
        check("ack_rise_ovf", 32'(ovf_status), 32'h040);
        check("ack_rise_valid", 32'(irq_valid), 32'd0);
        serve("ch6_rereq", 1'b1, gap);
        idle(6);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;

        // ch0 pulsed 300 times: counter saturates at 255.
        exp_q.push_back(0);
        for (int i = 0; i < 300; i++) begin
            data_event_intr = 10'h001;
            tick();
            data_event_intr = '0;
            tick();
        end
        cnt_sel = 4'd0;
        tick();
        check("sat_cnt", 32'(cnt_val), 32'd255);
        check("sat_ovf", 32'(ovf_status), 32'h001);
        serve("ch0", 1'b0, gap);

        // Reset during REQ drops the request without ack.
        adc_wclk_rst = 1'b1;
        tick();
        check("midreq_rst_valid", 32'(irq_valid), 32'd0);
        check("midreq_rst_pend", 32'(pend_status), 32'd0);
        check("midreq_rst_ovf", 32'(ovf_status), 32'd0);
        check("midreq_rst_cnt_val", 32'(cnt_val), 32'd0);
        adc_wclk_rst = 1'b0;
        idle(2);
        check("post_rst_cnt", 32'(cnt_val), 32'd0);
        check("post_rst_valid", 32'(irq_valid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
